// File: rtl/i2c_write_sequencer_pkg.sv
// Shared definitions for the I2C write sequencer: FSM state encodings and the I2C write bit.
// The bench imports this package so that both sides agree on the encodings.
package i2c_write_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_ISSUE_START  = 4'd1,
    S_WAIT_HOLD    = 4'd2,
    S_SEND         = 4'd3,
    S_WAIT_BYTE    = 4'd4,
    S_ISSUE_STOP   = 4'd5,
    S_WAIT_STOP_LO = 4'd6,
    S_WAIT_STOP_HI = 4'd7,
    S_DONE         = 4'd8
  } state_t;

  localparam logic I2C_WRITE_BIT = 1'b0;

  // States in which the sequencer is blocked on the master (watchdog-supervised)
  function automatic logic is_wait_state(input state_t s);
    return s inside {S_ISSUE_START, S_WAIT_HOLD, S_WAIT_BYTE, S_WAIT_STOP_LO, S_WAIT_STOP_HI};
  endfunction

endpackage

// File: rtl/i2c_write_sequencer_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from the valid pair, pointer
// moves to the requester that was not just served when advanced.
module i2c_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_ptr
);

  logic r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= 1'b0;
    else if (i_advance)
      r_ptr <= ~i_last;
  end

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11)
      o_grant = r_ptr ? 2'b10 : 2'b01;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/i2c_write_sequencer.sv
// Two-requester I2C write transaction sequencer in front of a byte-level master.
// Optional watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_write_sequencer
  import i2c_write_sequencer_pkg::*;
#(
  parameter int LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [6:0]       req0_addr,
  input  logic [LEN_W-1:0] req0_len,
  input  logic [7:0]       req0_data,
  output logic             req0_pop,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [6:0]       req1_addr,
  input  logic [LEN_W-1:0] req1_len,
  input  logic [7:0]       req1_data,
  output logic             req1_pop,
  output logic             req1_done,
  input  logic             m_ready,
  input  logic             m_tx_done,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_i2c_en,
  output logic [7:0]       m_tx_data,
  output logic             busy,
  output logic             err
);

  state_t           r_state, w_state_next;
  logic             r_gnt;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [1:0]       w_grant;
  logic             w_ptr;
  logic             w_advance;
  logic             w_abort;
  logic             w_pick;
  logic [7:0]       w_payload;
  logic             r_start, r_stop, r_en, r_pop0, r_pop1, r_done0, r_done1, r_busy;
  logic [7:0]       r_tx_data;

  i2c_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   ({req1_valid, req0_valid}),
    .i_advance (w_advance),
    .i_last    (r_gnt),
    .o_grant   (w_grant),
    .o_ptr     (w_ptr)
  );

  assign w_pick    = w_grant[1];
  assign w_payload = r_gnt ? req1_data : req0_data;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic            w_timeout;

  assign w_timeout = is_wait_state(r_state) && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign w_abort   = w_timeout;
  assign err       = r_err;

  // Counts cycles spent in one supervised state; any state change restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_state_next != r_state || !is_wait_state(r_state))
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE:         if (m_ready && (|w_grant)) w_state_next = S_ISSUE_START;
      S_ISSUE_START:  if (m_tx_done) w_state_next = S_WAIT_HOLD;
      S_WAIT_HOLD:    if (m_ready) w_state_next = (r_cnt < r_len) ? S_SEND : S_ISSUE_STOP;
      S_SEND:         w_state_next = S_WAIT_BYTE;
      S_WAIT_BYTE:    if (m_tx_done) w_state_next = S_WAIT_HOLD;
      S_ISSUE_STOP:   w_state_next = S_WAIT_STOP_LO;
      S_WAIT_STOP_LO: if (!m_ready) w_state_next = S_WAIT_STOP_HI;
      S_WAIT_STOP_HI: if (m_ready) w_state_next = S_DONE;
      S_DONE: begin
        w_state_next = S_IDLE;
        w_advance    = 1'b1;
      end
      default:        w_state_next = S_IDLE;
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_advance    = 1'b1;
    end
`endif
  end

  // Outputs are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_en      <= 1'b0;
      r_tx_data <= 8'h00;
      r_pop0    <= 1'b0;
      r_pop1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_state_next == S_ISSUE_START) begin
        r_gnt     <= w_pick;
        r_len     <= w_pick ? req1_len : req0_len;
        r_cnt     <= '0;
        r_tx_data <= {(w_pick ? req1_addr : req0_addr), I2C_WRITE_BIT};
      end else if (w_state_next == S_SEND) begin
        r_tx_data <= w_payload;
      end else if (w_abort) begin
        r_tx_data <= 8'h00;
      end
      // Compare-before-increment keeps cnt within LEN_W bits at the maximum length
      if (r_state == S_SEND)
        r_cnt <= r_cnt + 1'b1;
      r_start <= (w_state_next == S_ISSUE_START);
      r_stop  <= (w_state_next == S_ISSUE_STOP);
      r_en    <= (w_state_next == S_ISSUE_START) || (w_state_next == S_SEND) ||
                 (w_state_next == S_ISSUE_STOP);
      r_pop0  <= (w_state_next == S_SEND) && !r_gnt;
      r_pop1  <= (w_state_next == S_SEND) && r_gnt;
      r_done0 <= ((w_state_next == S_DONE) || w_abort) && !r_gnt;
      r_done1 <= ((w_state_next == S_DONE) || w_abort) && r_gnt;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign m_start   = r_start;
  assign m_stop    = r_stop;
  assign m_i2c_en  = r_en;
  assign m_tx_data = r_tx_data;
  assign req0_pop  = r_pop0;
  assign req1_pop  = r_pop1;
  assign req0_done = r_done0;
  assign req1_done = r_done1;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer with a behavioural byte-level master model.
// Define I2C_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=64).
module tb_i2c_write_sequencer;
  import i2c_write_sequencer_pkg::*;

  localparam int LEN_W = 4;
  localparam int HALF  = 10;
  localparam int FBYTE = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_pop, req1_pop, req0_done, req1_done;
  logic m_ready, m_tx_done;
  logic m_start, m_stop, m_i2c_en, busy, err;
  logic [7:0] m_tx_data;

  always #5 clk = ~clk;

  i2c_write_sequencer #(
    .LEN_W(LEN_W)
`ifdef I2C_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len),
    .req0_data(req0_data), .req0_pop(req0_pop), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len),
    .req1_data(req1_data), .req1_pop(req1_pop), .req1_done(req1_done),
    .m_ready(m_ready), .m_tx_done(m_tx_done), .m_start(m_start), .m_stop(m_stop),
    .m_i2c_en(m_i2c_en), .m_tx_data(m_tx_data), .busy(busy), .err(err)
  );

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- master model ----------------
  localparam int MI = 0, MS = 1, MB = 2, MG = 3, MP = 4;
  int mst, mcnt;
  logic [7:0] m_byte;
  logic hang = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready   <= 1'b1;
      m_tx_done <= 1'b0;
      mst       <= MI;
      mcnt      <= 0;
      m_byte    <= 8'h00;
    end else begin
      case (mst)
        MI: begin
          if (m_i2c_en && m_start) begin
            m_byte <= m_tx_data; m_ready <= 1'b0; mcnt <= 0; mst <= MS;
          end else if (m_i2c_en && m_stop) begin
            m_ready <= 1'b0; mcnt <= 0; mst <= MP;
          end else if (m_i2c_en) begin
            m_byte <= m_tx_data; m_ready <= 1'b0; mcnt <= 0; mst <= MB;
          end
        end
        MS: begin
          mcnt <= mcnt + 1;
          if (mcnt == HALF) m_ready <= 1'b1;
          else if (mcnt == HALF + 1) m_ready <= 1'b0;
          if (!hang && mcnt == HALF + FBYTE) begin
            m_tx_done <= 1'b1; m_ready <= 1'b1; mst <= MG;
          end
        end
        MB: begin
          mcnt <= mcnt + 1;
          if (mcnt == FBYTE) begin
            m_tx_done <= 1'b1; m_ready <= 1'b1; mst <= MG;
          end
        end
        MG: begin
          m_tx_done <= 1'b0; mst <= MI;
        end
        MP: begin
          mcnt <= mcnt + 1;
          if (mcnt == 2 * HALF) begin
            m_ready <= 1'b1; mst <= MI;
          end
        end
        default: mst <= MI;
      endcase
    end
  end

  // ---------------- requesters (FWFT queues) ----------------
  typedef logic [7:0] byte_q_t[$];
  byte_q_t q0, q1;

  always @(negedge clk) begin
    if (req0_pop && q0.size() > 0) void'(q0.pop_front());
    if (req1_pop && q1.size() > 0) void'(q1.pop_front());
    if (req0_done) req0_valid = 1'b0;
    if (req1_done) req1_valid = 1'b0;
    req0_data = (q0.size() > 0) ? q0[0] : 8'h00;
    req1_data = (q1.size() > 0) ? q1[0] : 8'h00;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int idx;
    int pops;
    int txd;
    int stops;
    int err;
  } exp_t;

  exp_t exp_done[$];
  logic [7:0] exp_byte[$];
  int pop_cnt[2];
  int txd_cnt, stop_cnt;

  always @(negedge clk) begin
    if (reset) begin
      pop_cnt[0] = 0; pop_cnt[1] = 0; txd_cnt = 0; stop_cnt = 0;
    end else begin
      if (m_start && m_stop) chk("start_and_stop", 1, 0);
      if (m_tx_done) begin
        txd_cnt++;
        if (exp_byte.size() == 0) chk("unexpected_byte", int'(m_byte), -1);
        else chk("sda_byte", int'(m_byte), int'(exp_byte.pop_front()));
      end
      if (req0_pop) pop_cnt[0]++;
      if (req1_pop) pop_cnt[1]++;
      if (m_stop && m_i2c_en) stop_cnt++;
      if (req0_done || req1_done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", {30'd0, req1_done, req0_done}, 0);
        end else begin
          exp_t e;
          e = exp_done.pop_front();
          chk("done_idx", req1_done ? 1 : 0, e.idx);
          chk("done_both", int'(req0_done && req1_done), 0);
          chk("pops", pop_cnt[e.idx], e.pops);
          chk("other_pops", pop_cnt[1 - e.idx], 0);
          chk("tx_done_count", txd_cnt, e.txd);
          chk("stop_count", stop_cnt, e.stops);
          chk("err", int'(err), e.err);
        end
        pop_cnt[0] = 0; pop_cnt[1] = 0; txd_cnt = 0; stop_cnt = 0;
      end
    end
  end

  // Loads a requester and pushes its expected bytes and completion record
  task automatic load(input int n, input logic [6:0] a, input int len, input byte_q_t d,
                      input bit expect_bytes);
    exp_t e;
    if (n == 0) begin
      q0 = d; req0_addr = a; req0_len = LEN_W'(len); req0_data = d.size() > 0 ? d[0] : 8'h00;
    end else begin
      q1 = d; req1_addr = a; req1_len = LEN_W'(len); req1_data = d.size() > 0 ? d[0] : 8'h00;
    end
    if (expect_bytes) begin
      exp_byte.push_back({a, 1'b0});
      for (int i = 0; i < len; i++) exp_byte.push_back(d[i]);
      e = '{idx: n, pops: len, txd: len + 1, stops: 1, err: 0};
    end else begin
      e = '{idx: n, pops: 0, txd: 0, stops: 0, err: 1};
    end
    exp_done.push_back(e);
  endtask

  task automatic wait_all(input int budget);
    int c;
    c = 0;
    while ((exp_done.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_budget", int'(c >= budget), 0);
    if (c >= budget) exp_done.delete();
    repeat (3) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({req0_pop, req1_pop, req0_done, req1_done, m_start, m_stop,
                 m_i2c_en, m_tx_data, busy, err});
  endfunction

  initial begin
    byte_q_t bq, bq1;
    int c;

    #1 chk("reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs_held", outs(), 0);
    reset = 1'b0;
    @(negedge clk);

    // Both valid in the same cycle: req0 first, then req1; repeated
    for (int r = 0; r < 2; r++) begin
      bq = {8'h11}; bq1 = {8'h22, 8'h33};
      load(0, 7'h0A, 1, bq, 1'b1);
      load(1, 7'h0B, 2, bq1, 1'b1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_all(2000);
    end

    // req0 addr 0x50, two payload bytes
    bq = {8'hA5, 8'h3C};
    load(0, 7'h50, 2, bq, 1'b1);
    req0_valid = 1'b1;
    wait_all(2000);

    // req1 address-only probe
    bq = {};
    load(1, 7'h21, 0, bq, 1'b1);
    req1_valid = 1'b1;
    wait_all(2000);
    chk("busy_after_probe", int'(busy), 0);

    // Maximum length: 15 pops, 16 tx_done pulses
    bq = {};
    for (int i = 0; i < 15; i++) bq.push_back(8'((i * 8'h11) ^ 8'h5A));
    load(0, 7'h3F, 15, bq, 1'b1);
    req0_valid = 1'b1;
    wait_all(4000);

    // Reset in the middle of the first payload byte
    bq = {8'hC1, 8'hC2, 8'hC3};
    load(0, 7'h33, 3, bq, 1'b1);
    req0_valid = 1'b1;
    c = 0;
    while (!req0_pop && c < 500) begin @(negedge clk); c++; end
    chk("first_pop_seen", int'(c < 500), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_done.delete(); exp_byte.delete(); q0.delete();
    req0_valid = 1'b0;
    #1 chk("mid_reset_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    chk("mid_reset_held", outs(), 0);
    reset = 1'b0;
    @(negedge clk);

    bq = {8'h77};
    load(0, 7'h50, 1, bq, 1'b1);
    req0_valid = 1'b1;
    wait_all(2000);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master stalls with ready low after the start phase
    hang = 1'b1;
    bq = {8'h99};
    load(0, 7'h10, 1, bq, 1'b0);
    req0_valid = 1'b1;
    c = 0;
    while (!m_start && c < 100) begin @(negedge clk); c++; end
    c = 0;
    while (!req0_done && c < 200) begin @(negedge clk); c++; end
    chk("watchdog_cycles", c, 64);
    chk("err_pulse", int'(err), 1);
    @(negedge clk);
    chk("err_one_cycle", int'(err), 0);
    chk("idle_after_abort", int'({busy, m_i2c_en, m_start, m_stop, m_tx_data}), 0);
`endif

    chk("leftover_bytes", exp_byte.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
